// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: Gray/binary conversion and prefetch depth.
// Conversions work on a 32-bit container, so callers cast to their pointer width.
package fifo_pkg;

   localparam int OB_DEPTH = 2;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Two-entry prefetch buffer in front of the consumer; head word is held in a register
// so rdata/rvalid come straight from flops.
module fifo_rd_obuf
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             wr_en,
   input  logic [DSIZE-1:0] wr_data,
   input  logic             pop,
   output logic             rvalid,
   output logic [DSIZE-1:0] rdata,
   output logic [1:0]       cnt
);

   logic [DSIZE-1:0] head_reg, head_next;
   logic [DSIZE-1:0] tail_reg, tail_next;
   logic [1:0]       cnt_reg, cnt_next;

   always_comb begin
      head_next = head_reg;
      tail_next = tail_reg;
      cnt_next  = cnt_reg;
      case ({wr_en, pop})
         2'b10: begin
            if (cnt_reg == 2'd0) head_next = wr_data;
            else                 tail_next = wr_data;
            cnt_next = cnt_reg + 2'd1;
         end
         2'b01: begin
            if (cnt_reg == 2'd2) head_next = tail_reg;
            cnt_next = cnt_reg - 2'd1;
         end
         2'b11: begin
            // count unchanged; the new word lands behind whatever remains
            if (cnt_reg == 2'd2) begin
               head_next = tail_reg;
               tail_next = wr_data;
            end else begin
               head_next = wr_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         head_reg <= '0;
         tail_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         head_reg <= head_next;
         tail_reg <= tail_next;
         cnt_reg  <= cnt_next;
      end
   end

   assign rvalid = (cnt_reg != 2'd0);
   assign rdata  = head_reg;
   assign cnt    = cnt_reg;

   a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
                                   !(wr_en && !pop && cnt_reg == 2'(OB_DEPTH)));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty flag, RAM fetch and FWFT output.
// Define FIFO_RD_LEVEL_EN to build the registered rlevel/raempty occupancy logic.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ASIZE         = 4,
   parameter int DSIZE         = 8,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [ASIZE:0]   rq2_wptr,
   output logic [ASIZE:0]   rptr,
   output logic [ASIZE-1:0] raddr,
   output logic             rmem_en,
   input  logic [DSIZE-1:0] rmem_data,
   output logic [DSIZE-1:0] rdata,
   output logic             rvalid,
   input  logic             rready,
   output logic             rempty,
   output logic             raempty,
   output logic [ASIZE+1:0] rlevel
);

   localparam int PW = ASIZE + 1;
   localparam int LW = ASIZE + 2;

   logic [ASIZE:0] rbin_reg, rbin_next;
   logic [ASIZE:0] rptr_reg, rgray_next;
   logic           rempty_reg;
   logic           inflight_reg;
   logic           pop;
   logic           fetch;
   logic [2:0]     space;
   logic [1:0]     ob_cnt;

   assign pop = rvalid && rready;

   // the in-flight word already owns a buffer slot, so fetching never overruns the buffer
   always_comb begin
      space      = 3'(OB_DEPTH) - 3'(ob_cnt) - 3'(inflight_reg) + 3'(pop);
      fetch      = !rempty_reg && (space != 3'd0) && rrst_n;
      rbin_next  = rbin_reg + PW'(fetch);
      rgray_next = PW'(bin2gray(32'(rbin_next)));
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rbin_reg     <= '0;
         rptr_reg     <= '0;
         rempty_reg   <= 1'b1;
         inflight_reg <= 1'b0;
      end else begin
         rbin_reg     <= rbin_next;
         rptr_reg     <= rgray_next;
         rempty_reg   <= (rgray_next == rq2_wptr);
         inflight_reg <= fetch;
      end
   end

   assign rmem_en = fetch;
   assign raddr   = rbin_reg[ASIZE-1:0];
   assign rptr    = rptr_reg;
   assign rempty  = rempty_reg;

   fifo_rd_obuf #(
      .DSIZE(DSIZE)
   ) u_obuf (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .wr_en   (inflight_reg),
      .wr_data (rmem_data),
      .pop     (pop),
      .rvalid  (rvalid),
      .rdata   (rdata),
      .cnt     (ob_cnt)
   );

`ifdef FIFO_RD_LEVEL_EN
   localparam logic [ASIZE:0] AE_TH = PW'(AEMPTY_THRESH);

   logic [ASIZE:0] wbin, diff_next;
   logic [LW-1:0]  ob_cnt_next, level_next;
   logic           raempty_reg;
   logic [LW-1:0]  rlevel_reg;

   always_comb begin
      wbin        = PW'(gray2bin(32'(rq2_wptr)));
      diff_next   = wbin - rbin_next;
      ob_cnt_next = LW'(ob_cnt) + LW'(inflight_reg) - LW'(pop);
      level_next  = LW'(diff_next) + LW'(fetch) + ob_cnt_next;
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         raempty_reg <= 1'b1;
         rlevel_reg  <= '0;
      end else begin
         raempty_reg <= (diff_next <= AE_TH);
         rlevel_reg  <= level_next;
      end
   end

   assign raempty = raempty_reg;
   assign rlevel  = rlevel_reg;
`else
   assign raempty = rempty_reg;
   assign rlevel  = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomised scoreboard bench for fifo_rd_ctrl with a word-count reference model.
module tb_fifo_rd_ctrl;

   localparam int ASIZE = 4;
   localparam int DSIZE = 8;
   localparam int AE    = 2;
   localparam int DEPTH = 16;

   logic             rclk = 1'b0;
   logic             rrst_n = 1'b0;
   logic [ASIZE:0]   rq2_wptr = '0;
   logic [ASIZE:0]   rptr;
   logic [ASIZE-1:0] raddr;
   logic             rmem_en;
   logic [DSIZE-1:0] rmem_data = '0;
   logic [DSIZE-1:0] rdata;
   logic             rvalid;
   logic             rready = 1'b0;
   logic             rempty;
   logic             raempty;
   logic [ASIZE+1:0] rlevel;

   fifo_rd_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AEMPTY_THRESH(AE)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rptr(rptr), .raddr(raddr),
      .rmem_en(rmem_en), .rmem_data(rmem_data), .rdata(rdata), .rvalid(rvalid),
      .rready(rready), .rempty(rempty), .raempty(raempty), .rlevel(rlevel)
   );

   always #5 rclk = ~rclk;

   int checks = 0;
   int errors = 0;

   logic [DSIZE-1:0] ram [DEPTH];
   logic [DSIZE-1:0] exp_q [$];
   int wbin = 0;
   int fetch_cnt = 0;
   int popped = 0;
   int fc_last = 0;
   int lvl_en;

   logic        chk_on = 1'b0;
   logic [4:0]  exp_rptr = '0;
   logic        exp_rempty = 1'b1;
   logic        exp_raempty = 1'b1;
   logic        exp_rvalid = 1'b0;
   int          exp_level = 0;
   logic        saw_wrap = 1'b0;
   logic [4:0]  prev_rptr = '0;

   function automatic logic [4:0] g5(input int b);
      logic [4:0] x;
      x = b[4:0];
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic next();
      @(posedge rclk);
      #1;
   endtask

   task automatic push_words(input int n);
      logic [DSIZE-1:0] d;
      for (int i = 0; i < n; i++) begin
         d = DSIZE'($urandom);
         ram[wbin % DEPTH] = d;
         exp_q.push_back(d);
         wbin++;
      end
      rq2_wptr = g5(wbin);
   endtask

   task automatic clear_model(input int n);
      exp_q.delete();
      wbin      = n;
      rq2_wptr  = g5(n);
      fetch_cnt = 0;
      popped    = 0;
   endtask

   task automatic do_reset();
      next();
      rrst_n = 1'b0;
      rready = 1'b0;
      clear_model(0);
      repeat (3) next();
      rrst_n = 1'b1;
   endtask

   // RAM with one-cycle registered read
   always @(posedge rclk) begin
      if (rmem_en) rmem_data <= ram[raddr];
   end

   // Expected state after each edge, from word counts only
   always @(posedge rclk) begin
      chk_on <= 1'b1;
      if (!rrst_n) begin
         exp_rptr    <= '0;
         exp_rempty  <= 1'b1;
         exp_raempty <= 1'b1;
         exp_level   <= 0;
         exp_rvalid  <= 1'b0;
         fc_last     <= 0;
      end else begin
         exp_rptr   <= g5(fetch_cnt);
         exp_rempty <= (fetch_cnt == wbin);
`ifdef FIFO_RD_LEVEL_EN
         exp_raempty <= ((wbin - fetch_cnt) <= AE);
         exp_level   <= wbin - popped;
`else
         exp_raempty <= (fetch_cnt == wbin);
         exp_level   <= 0;
`endif
         exp_rvalid <= ((fc_last - popped) > 0);
         fc_last    <= fetch_cnt;
      end
   end

   // Monitor: per-cycle state, fetch addresses, and scoreboard on each transfer
   always @(negedge rclk) begin
      if (chk_on) begin
         chk("rptr", 32'(rptr), 32'(exp_rptr));
         chk("rempty", 32'(rempty), 32'(exp_rempty));
         chk("raempty", 32'(raempty), 32'(exp_raempty));
         chk("rlevel", 32'(rlevel), 32'(exp_level));
         chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
         if (prev_rptr == 5'b10000 && rptr == 5'b00000) saw_wrap = 1'b1;
         prev_rptr = rptr;
         if (rmem_en) begin
            chk("raddr", 32'(raddr), 32'(fetch_cnt % DEPTH));
            chk("fetch_avail", 32'(fetch_cnt < wbin), 32'd1);
            fetch_cnt++;
         end
         if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stale_word actual=%0h required=none t=%0t", rdata, $time);
            end else begin
               chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
            end
            popped++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int guard;
`ifdef FIFO_RD_LEVEL_EN
      lvl_en = 1;
`else
      lvl_en = 0;
`endif
      // reset with a non-empty write pointer present
      next();
      rrst_n = 1'b0;
      clear_model(6);
      repeat (3) next();
      @(negedge rclk);
      chk("rst_rptr", 32'(rptr), 32'd0);
      chk("rst_rempty", 32'(rempty), 32'd1);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rmem_en", 32'(rmem_en), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      next();
      rrst_n = 1'b1;
      @(negedge rclk);
      chk("rel_rempty_hold", 32'(rempty), 32'd1);
      @(negedge rclk);
      chk("rel_rempty", 32'(rempty), 32'd0);
      chk("rel_rmem_en", 32'(rmem_en), 32'd1);

      // single word latency
      do_reset();
      rready = 1'b1;
      push_words(1);
      @(negedge rclk);
      chk("sw_rmem_en0", 32'(rmem_en), 32'd0);
      @(negedge rclk);
      chk("sw_rempty0", 32'(rempty), 32'd0);
      chk("sw_rmem_en1", 32'(rmem_en), 32'd1);
      chk("sw_raddr", 32'(raddr), 32'd0);
      @(negedge rclk);
      chk("sw_rvalid_early", 32'(rvalid), 32'd0);
      chk("sw_rptr", 32'(rptr), 32'd1);
      chk("sw_rempty1", 32'(rempty), 32'd1);
      @(negedge rclk);
      chk("sw_rvalid", 32'(rvalid), 32'd1);
      chk("sw_rdata", 32'(rdata), 32'(ram[0]));
      @(negedge rclk);
      chk("sw_rvalid_pulse", 32'(rvalid), 32'd0);

      // stall with 5 words, then burst out
      do_reset();
      push_words(5);
      repeat (8) next();
      @(negedge rclk);
      chk("stall_fetches", 32'(fetch_cnt), 32'd2);
      chk("stall_rptr", 32'(rptr), 32'(g5(2)));
      chk("stall_rvalid", 32'(rvalid), 32'd1);
      chk("stall_level", 32'(rlevel), lvl_en ? 32'd5 : 32'd0);
      next();
      rready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge rclk);
         chk("burst_nogap", 32'(rvalid), 32'd1);
      end
      @(negedge rclk);
      chk("burst_end", 32'(rvalid), 32'd0);

      // random stream across pointer wrap
      sent  = 0;
      guard = 0;
      while (sent < 40 && guard < 2000) begin
         next();
         rready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1 && (wbin - popped) < DEPTH) begin
            push_words(1);
            sent++;
         end
         guard++;
      end
      chk("stream_sent", 32'(sent), 32'd40);
      next();
      rready = 1'b1;
      guard  = 0;
      while ((exp_q.size() != 0 || rvalid) && guard < 300) begin
         next();
         guard++;
      end
      chk("drain_done", 32'(exp_q.size()), 32'd0);
      chk("rptr_wrap_seen", 32'(saw_wrap), 32'd1);
      @(negedge rclk);
      chk("drain_rptr", 32'(rptr), 32'(g5(wbin)));

      // reset while a word is in flight
      do_reset();
      push_words(3);
      guard = 0;
      do begin
         @(negedge rclk);
         guard++;
      end while (!rmem_en && guard < 20);
      chk("mid_fetch_seen", 32'(rmem_en), 32'd1);
      next();
      rrst_n = 1'b0;
      clear_model(0);
      @(negedge rclk);
      @(negedge rclk);
      chk("mid_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rptr", 32'(rptr), 32'd0);
      repeat (2) next();
      rrst_n = 1'b1;
      rready = 1'b1;
      repeat (10) next();
      @(negedge rclk);
      chk("mid_no_stale", 32'(rvalid), 32'd0);

      // occupancy: 6 words held, then pop 4
      do_reset();
      push_words(6);
      repeat (8) next();
      @(negedge rclk);
      chk("lvl6", 32'(rlevel), lvl_en ? 32'd6 : 32'd0);
      chk("lvl6_raempty", 32'(raempty), 32'd0);
      next();
      rready = 1'b1;
      repeat (4) next();
      rready = 1'b0;
      repeat (4) next();
      @(negedge rclk);
      chk("lvl2", 32'(rlevel), lvl_en ? 32'd2 : 32'd0);
      chk("lvl2_raempty", 32'(raempty), 32'd1);
      chk("lvl2_popped", 32'(popped), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
